// File: rtl/player_defs_pkg.sv
// Constants shared by the player controller and the player datapath:
// FSM encodings, sprite geometry, colours and lane positions.
package player_defs;

  typedef enum logic [2:0] {
    S_INIT         = 3'd0,
    S_INPUT        = 3'd1,
    S_SET_A        = 3'd2,
    S_SET_D        = 3'd3,
    S_ERASE        = 3'd4,
    S_UPDATE       = 3'd5,
    S_DRAW         = 3'd6,
    S_WAIT_RELEASE = 3'd7
  } state_t;

  localparam int         DEF_SPRITE_W      = 12;
  localparam int         DEF_SPRITE_H      = 12;
  localparam logic [2:0] DEF_PLAYER_COLOUR = 3'b111;
  localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;

  localparam int         NUM_LANES = 4;
  localparam logic [7:0] PLAYER_Y  = 8'd99;

  // Left edge of each lane, indexed 0 (leftmost) to 3.
  function automatic logic [7:0] lane_x(input logic [1:0] lane);
    logic [7:0] x;
    case (lane)
      2'd0:    x = 8'd14;
      2'd1:    x = 8'd54;
      2'd2:    x = 8'd94;
      default: x = 8'd134;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/sprite_sweep_counter.sv
// Raster offset generator for one sprite pass: x fastest, one pixel per
// cycle while run is high, self-clearing after the last pixel.
module sprite_sweep_counter #(
  parameter int W = 12,
  parameter int H = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  output logic [3:0] x_offset,
  output logic [3:0] y_offset,
  output logic       last
);

  localparam logic [3:0] X_MAX = 4'(W - 1);
  localparam logic [3:0] Y_MAX = 4'(H - 1);

  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    last = run && (x_q == X_MAX) && (y_q == Y_MAX);
    // Idle passes park at the origin so the next pass starts at (0,0).
    if (!run) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == X_MAX) begin
      x_d = '0;
      y_d = (y_q == Y_MAX) ? 4'd0 : y_q + 4'd1;
    end else begin
      x_d = x_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_offset = x_q;
  assign y_offset = y_q;

endmodule

// File: rtl/player_control.sv
// Player controller: turns A/D key levels into datapath strobes and runs the
// erase/draw sprite sweeps around each position update.
module player_control
  import player_defs::*;
#(
  parameter int         SPRITE_W      = DEF_SPRITE_W,
  parameter int         SPRITE_H      = DEF_SPRITE_H,
  parameter logic [2:0] PLAYER_COLOUR = DEF_PLAYER_COLOUR,
  parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       keyboardAPressed,
  input  logic       keyboardDPressed,
  output logic       inInputState,
  output logic       inSetAState,
  output logic       inSetDState,
  output logic       inUpdatePositionState,
  output logic       plot,
  output logic [2:0] colour,
  output logic [3:0] x_offset,
  output logic [3:0] y_offset,
  output logic       busy,
  output logic       move_done
);

  state_t     state_q, state_d;
  logic       move_done_q, move_done_d;
  logic       sweep_run;
  logic       sweep_last;
  logic [3:0] sweep_x;
  logic [3:0] sweep_y;

  assign sweep_run = (state_q == S_ERASE) || (state_q == S_DRAW);

  sprite_sweep_counter #(
    .W(SPRITE_W),
    .H(SPRITE_H)
  ) u_sweep (
    .clock    (clock),
    .reset    (reset),
    .run      (sweep_run),
    .x_offset (sweep_x),
    .y_offset (sweep_y),
    .last     (sweep_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_DRAW;
      S_INPUT: begin
        if (enable && keyboardAPressed && !keyboardDPressed)
          state_d = S_SET_A;
        else if (enable && keyboardDPressed && !keyboardAPressed)
          state_d = S_SET_D;
      end
      S_SET_A, S_SET_D: state_d = S_ERASE;
      S_ERASE:          if (sweep_last) state_d = S_UPDATE;
      S_UPDATE:         state_d = S_DRAW;
      S_DRAW:           if (sweep_last) state_d = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (!keyboardAPressed && !keyboardDPressed) state_d = S_INPUT;
      end
      default: state_d = S_INIT;
    endcase
    // Registered so the pulse is a pure function of flop state.
    move_done_d = (state_d == S_WAIT_RELEASE) && (state_q != S_WAIT_RELEASE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_INIT;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_done_q <= move_done_d;
    end
  end

  always_comb begin
    inInputState          = 1'b0;
    inSetAState           = 1'b0;
    inSetDState           = 1'b0;
    inUpdatePositionState = 1'b0;
    plot                  = 1'b0;
    colour                = 3'b000;
    x_offset              = 4'd0;
    y_offset              = 4'd0;
    busy                  = (state_q != S_INPUT) && (state_q != S_INIT);
    move_done             = move_done_q;
    case (state_q)
      S_INPUT:  inInputState          = 1'b1;
      S_SET_A:  inSetAState           = 1'b1;
      S_SET_D:  inSetDState           = 1'b1;
      S_UPDATE: inUpdatePositionState = 1'b1;
      S_ERASE: begin
        plot     = 1'b1;
        colour   = BG_COLOUR;
        x_offset = sweep_x;
        y_offset = sweep_y;
      end
      S_DRAW: begin
        plot     = 1'b1;
        colour   = PLAYER_COLOUR;
        x_offset = sweep_x;
        y_offset = sweep_y;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_player_control.sv
// Scoreboard bench for player_control: stimulus queues the expected output
// vector of every cycle, a negedge monitor pops and compares.
module tb_player_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       key_a;
  logic       key_d;
  logic       in_input, set_a, set_d, upd, plot, busy, move_done;
  logic [2:0] colour;
  logic [3:0] x_offset, y_offset;

  always #5 clock = ~clock;

  player_control dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .keyboardAPressed      (key_a),
    .keyboardDPressed      (key_d),
    .inInputState          (in_input),
    .inSetAState           (set_a),
    .inSetDState           (set_d),
    .inUpdatePositionState (upd),
    .plot                  (plot),
    .colour                (colour),
    .x_offset              (x_offset),
    .y_offset              (y_offset),
    .busy                  (busy),
    .move_done             (move_done)
  );

  typedef struct packed {
    logic       in_input;
    logic       set_a;
    logic       set_d;
    logic       upd;
    logic       plot;
    logic [2:0] colour;
    logic [3:0] xo;
    logic [3:0] yo;
    logic       busy;
    logic       move_done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle = 0;
  int   md_total = 0;
  int   upd_total = 0;
  int   md_last = 0;
  int   md_prev = 0;

  function automatic exp_t e_init();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t e_input();
    exp_t e = '0;
    e.in_input = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_set(input logic is_a);
    exp_t e = '0;
    e.set_a = is_a;
    e.set_d = !is_a;
    e.busy  = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_pix(input logic [2:0] col, input int x, input int y);
    exp_t e = '0;
    e.plot   = 1'b1;
    e.colour = col;
    e.xo     = 4'(x);
    e.yo     = 4'(y);
    e.busy   = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_upd();
    exp_t e = '0;
    e.upd  = 1'b1;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_wait(input logic md);
    exp_t e = '0;
    e.busy      = 1'b1;
    e.move_done = md;
    return e;
  endfunction

  task automatic cyc(input exp_t e);
    @(posedge clock);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic sweep(input logic [2:0] col);
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 12; x++)
        cyc(e_pix(col, x, y));
  endtask

  // Erase at old position, update strobe, draw at new, then move_done.
  task automatic move_body();
    sweep(3'b000);
    cyc(e_upd());
    sweep(3'b111);
    cyc(e_wait(1'b1));
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_ge(input string name, input int got, input int min_val);
    n_checks++;
    if (got < min_val) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected at least %0d", name, got, min_val);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cycle++;
  end

  initial forever begin
    exp_t e;
    exp_t act;
    @(negedge clock);
    act = {in_input, set_a, set_d, upd, plot, colour, x_offset, y_offset, busy, move_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL outputs cycle=%0d got in/a/d/upd/plot=%b%b%b%b%b col=%0d off=(%0d,%0d) busy=%b md=%b expected in/a/d/upd/plot=%b%b%b%b%b col=%0d off=(%0d,%0d) busy=%b md=%b",
                 cycle, act.in_input, act.set_a, act.set_d, act.upd, act.plot, act.colour,
                 act.xo, act.yo, act.busy, act.move_done,
                 e.in_input, e.set_a, e.set_d, e.upd, e.plot, e.colour, e.xo, e.yo,
                 e.busy, e.move_done);
      end
    end
    if (move_done === 1'b1) begin
      md_total++;
      md_prev = md_last;
      md_last = cycle;
      $display("move %0d complete at cycle %0d", md_total, cycle);
    end
    if (upd === 1'b1) upd_total++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cycle);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int md_base;
    int upd_base;
    reset  = 1'b0;
    enable = 1'b1;
    key_a  = 1'b0;
    key_d  = 1'b0;

    // Reset held, then released: one idle cycle, initial draw, move_done.
    $display("phase: reset and initial draw");
    repeat (3) cyc(e_init());
    reset = 1'b1;
    sweep(3'b111);
    cyc(e_wait(1'b1));
    cyc(e_input());
    cyc(e_input());

    $display("phase: A held through a full move");
    key_a = 1'b1;
    cyc(e_set(1'b1));
    move_body();
    repeat (10) cyc(e_wait(1'b0));
    key_a = 1'b0;
    cyc(e_input());

    $display("phase: A and D together");
    key_a = 1'b1;
    key_d = 1'b1;
    repeat (20) cyc(e_input());
    key_a = 1'b0;
    key_d = 1'b0;
    cyc(e_input());

    $display("phase: enable low with D held");
    enable = 1'b0;
    key_d  = 1'b1;
    repeat (5) cyc(e_input());
    enable = 1'b1;
    cyc(e_set(1'b0));
    key_d = 1'b0;
    move_body();
    cyc(e_input());

    $display("phase: reset during erase pixel 50");
    key_d = 1'b1;
    cyc(e_set(1'b0));
    key_d = 1'b0;
    for (int p = 0; p <= 50; p++) cyc(e_pix(3'b000, p % 12, p / 12));
    reset = 1'b0;
    cyc(e_init());
    reset = 1'b1;
    sweep(3'b111);
    cyc(e_wait(1'b1));
    cyc(e_input());

    $display("phase: two separate presses");
    md_base  = md_total;
    upd_base = upd_total;
    key_a = 1'b1;
    cyc(e_set(1'b1));
    key_a = 1'b0;
    move_body();
    cyc(e_input());
    repeat (3) cyc(e_input());
    key_d = 1'b1;
    cyc(e_set(1'b0));
    key_d = 1'b0;
    move_body();
    cyc(e_input());
    @(negedge clock);
    #1;
    check_int("move_done_pulses", md_total - md_base, 2);
    check_int("update_pulses", upd_total - upd_base, 2);
    check_ge("move_done_spacing", md_last - md_prev, 291);

    repeat (2) @(negedge clock);
    #1;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
